dmem_lsu: RTL and testbench
===========================

Name: dmem_lsu

Overview:
Load/store unit: the initiator side of the data-memory port. Accepts one load or store request at a time from the MEM pipeline stage. For stores it drives the address, byte enables and lane-replicated write data. For loads it captures the memory's registered read word one cycle later, then selects the lane and sign- or zero-extends it. It returns a single response per request, with a misalignment flag, to the writeback path.

Parameters:
ADDR_W, 12, byte-address bits decoded by the data memory (1024 words × 4 bytes)
TAG_W, 5, width of the destination-register tag carried request to response

Ports:
clk  in  1  clock; all state updates on posedge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  request accepted when req_valid && req_ready
req_store  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned  in  1  load zero-extends when 1 (ignored for stores)
req_addr  in  32  byte address
req_wdata  in  32  store data, right-justified
req_tag  in  TAG_W  destination tag
resp_valid  out  1  response present
resp_ready  in  1  response consumed when resp_valid && resp_ready
resp_data  out  32  extended load data; 0 for stores and faults
resp_tag  out  TAG_W  tag of the completing request
resp_misalign  out  1  request faulted; no memory access was made
mem_we  out  1  memory write enable
mem_addr  out  32  memory address (word-aligned: low two bits forced 0)
mem_wdata_sel  out  4  byte enables, bit i = byte lane i
mem_wdata  out  32  write data
mem_rdata  in  32  memory read word, valid the cycle after the address is presented

Behaviour:
- FSM states: IDLE, LOAD_WAIT, RESP. Reset → IDLE.
- Reset values: req_ready=1 (IDLE), resp_valid=0, resp_data=0, resp_tag=0, resp_misalign=0.
- mem_we is forced to 0 while rst_n is low.
- req_ready = (state==IDLE). The request is accepted in IDLE only.
- Memory outputs are combinational from the request in the accept cycle:
  - mem_addr = {req_addr[31:2],2'b00}
  - mem_we = accept && req_store && !fault
  - mem_addr and mem_wdata_sel are don't-care when not accepting; mem_wdata_sel=0 outside store accept.
- Fault (misalign) when any of the following holds:
  - size==11
  - size==01 with addr[0]==1
  - size==10 with addr[1:0]!=0
- Byte enables (off=addr[1:0]):
  - byte: 4'b0001<<off
  - half: 4'b0011<<off
  - word: 4'b1111
- Write data:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata
- Accepted store or fault: next state RESP. Response registered at the accept edge; resp_valid high in the next cycle. Store: resp_data=0, resp_misalign=0. Fault: resp_misalign=1, no mem_we.
- Accepted aligned load:
  - Register off, size, unsigned and tag; next state LOAD_WAIT.
  - In LOAD_WAIT, mem_rdata is valid. Select lane: byte → rdata[8*off+:8], half → rdata[16*off[1]+:16].
  - Extend with sign (!unsigned) or zeros, and register the result into resp_data. Next state RESP.
- Load-to-response latency: resp_valid asserts 2 cycles after the accept edge.
- RESP: hold all resp_* stable until resp_ready. On resp_valid && resp_ready → IDLE, resp_valid=0.
  - A new request cannot be accepted in that same cycle. Minimum spacing: 2 cycles for a store, 3 cycles for a load.
- req_wdata and req_addr are sampled only at accept; changes afterwards have no effect.
- Asynchronous reset mid-LOAD_WAIT or mid-RESP: return to IDLE and drop the pending response. A write already issued stays written.

Optional Feature:
DMEM_LSU_BOUND_CHK_EN:
- Defined: a request with req_addr[31:ADDR_W] != 0 faults exactly like a misalignment. resp_misalign=1, no memory access.
- Undefined: upper address bits pass through unchecked; the memory aliases them.

Decomposition:
- Package dmem_lsu_pkg holds:
  - SIZE_BYTE/SIZE_HALF/SIZE_WORD constants
  - FSM state encoding (IDLE=0, LOAD_WAIT=1, RESP=2)
  - byte-enable base patterns
- One combinational sub-module, dmem_lsu_align: inputs rdata, off, size, unsigned; output extended 32-bit word. The FSM and store path stay in dmem_lsu.

Test Plan:
- SW addr=0x10 wdata=0xDEADBEEF → mem_we=1, sel=1111, mem_addr=0x10; resp_valid next cycle, resp_misalign=0, resp_data=0.
- SB addr=0x13 wdata=0x000000A5 → sel=1000, mem_wdata=0xA5A5A5A5. Then LBU 0x13 with mem_rdata=0xA5000000 → resp_data=0x000000A5. LB 0x13 → 0xFFFFFFA5, latency 2 cycles.
- LH addr=0x22, mem_rdata=0x8001_1234 → resp_data=0xFFFF8001. LHU → 0x00008001.
- LW addr=0x06 → no mem_we, resp_misalign=1, resp_data=0, resp_tag=req_tag. SH addr=0x01 → same fault.
- Response held with resp_ready=0 for 5 cycles → resp_* stable, req_ready=0. Release → IDLE next cycle. Assert rst_n=0 during LOAD_WAIT → resp_valid=0 and req_ready=1 immediately.
- With DMEM_LSU_BOUND_CHK_EN: SW addr=0x1000 → resp_misalign=1, mem_we=0. Without the macro: write occurs with mem_addr=0x1000.

Source files
------------

// File: rtl/dmem_lsu_pkg.sv
// -----------------------------------------------------------------------------
// dmem_lsu_pkg
// Shared definitions for the data-memory load/store unit:
//   - access size encodings (byte / half / word / illegal)
//   - FSM state encoding
//   - byte-enable base patterns (shifted by the address offset)
//   - is_misaligned(): alignment rule for a size/offset pair
// -----------------------------------------------------------------------------
package dmem_lsu_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_ILL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD_WAIT = 2'd1,
        ST_RESP      = 2'd2
    } lsu_state_t;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    // Illegal size always faults; halves need an even address, words need a
    // 4-byte aligned address. Bytes are always aligned.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = off[0];
            SIZE_WORD: bad = (off != 2'b00);
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_lsu_align.sv
// -----------------------------------------------------------------------------
// dmem_lsu_align
// Combinational load-data path: picks the addressed byte or halfword out of
// the memory read word and sign- or zero-extends it to 32 bits.
// Ports:
//   rdata       in  32  registered memory read word
//   off         in  2   byte offset of the load address
//   size        in  2   access size (byte / half / word)
//   is_unsigned in  1   1 = zero-extend, 0 = sign-extend
//   data        out 32  extended load result
// -----------------------------------------------------------------------------
module dmem_lsu_align
    import dmem_lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = rdata[8*off +: 8];
        // Halfwords are only ever even-aligned here, so off[1] picks the half.
        lane_h = off[1] ? rdata[31:16] : rdata[15:0];
        data   = rdata;
        case (size)
            SIZE_BYTE: data = is_unsigned ? {24'd0, lane_b}
                                          : {{24{lane_b[7]}}, lane_b};
            SIZE_HALF: data = is_unsigned ? {16'd0, lane_h}
                                          : {{16{lane_h[15]}}, lane_h};
            default:   data = rdata;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// -----------------------------------------------------------------------------
// dmem_lsu
// Load/store unit on the initiator side of the data-memory port. Takes one
// request at a time from the MEM stage, drives the memory in the accept cycle,
// and returns exactly one response per request to writeback.
//
// Optional feature (compile-time macro): DMEM_LSU_BOUND_CHK_EN
//   defined   : req_addr[31:ADDR_W] != 0 faults like a misalignment
//   undefined : upper address bits pass through; the memory aliases them
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready are
// both high; valid may not depend on ready, and the payload is held stable
// while valid is high and ready is low.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        request handshake (ready only in IDLE)
//   req_store, req_size,
//   req_unsigned, req_addr,
//   req_wdata, req_tag         request payload (sampled only at accept)
//   resp_valid/resp_ready      response handshake
//   resp_data, resp_tag,
//   resp_misalign              response payload, held while waiting
//   mem_we, mem_addr,
//   mem_wdata_sel, mem_wdata   memory request, combinational in accept cycle
//   mem_rdata                  memory read word, valid one cycle after address
// -----------------------------------------------------------------------------
module dmem_lsu
    import dmem_lsu_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int TAG_W  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_store,
    input  logic [1:0]       req_size,
    input  logic             req_unsigned,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    input  logic [TAG_W-1:0] req_tag,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_data,
    output logic [TAG_W-1:0] resp_tag,
    output logic             resp_misalign,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [3:0]       mem_wdata_sel,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata
);

    lsu_state_t  state;

    logic        accept;
    logic        oob;
    logic        fault;
    logic        store_go;
    logic [1:0]  off;
    logic [3:0]  be;

    // Load context held across LOAD_WAIT (the request bus is free by then).
    logic [1:0]  ld_off;
    logic [1:0]  ld_size;
    logic        ld_unsigned;
    logic [31:0] ld_data;

    assign req_ready = (state == ST_IDLE);
    assign accept    = req_valid && req_ready;
    assign off       = req_addr[1:0];

`ifdef DMEM_LSU_BOUND_CHK_EN
    assign oob = |req_addr[31:ADDR_W];
`else
    assign oob = 1'b0;
`endif

    assign fault    = is_misaligned(req_size, off) || oob;
    // rst_n gates the write strobe so nothing is written while reset is held.
    assign store_go = rst_n && accept && req_store && !fault;

    assign mem_we   = store_go;
    assign mem_addr = {req_addr[31:2], 2'b00};

    always_comb begin
        be        = BE_WORD;
        mem_wdata = req_wdata;
        case (req_size)
            SIZE_BYTE: begin
                be        = BE_BYTE << off;
                mem_wdata = {4{req_wdata[7:0]}};
            end
            SIZE_HALF: begin
                be        = BE_HALF << off;
                mem_wdata = {2{req_wdata[15:0]}};
            end
            default: begin
                be        = BE_WORD;
                mem_wdata = req_wdata;
            end
        endcase
    end

    assign mem_wdata_sel = store_go ? be : 4'b0000;

    dmem_lsu_align u_align (
        .rdata       (mem_rdata),
        .off         (ld_off),
        .size        (ld_size),
        .is_unsigned (ld_unsigned),
        .data        (ld_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            resp_valid    <= 1'b0;
            resp_data     <= 32'd0;
            resp_tag      <= '0;
            resp_misalign <= 1'b0;
            ld_off        <= 2'b00;
            ld_size       <= SIZE_BYTE;
            ld_unsigned   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        resp_tag  <= req_tag;
                        resp_data <= 32'd0;
                        if (fault) begin
                            resp_misalign <= 1'b1;
                            resp_valid    <= 1'b1;
                            state         <= ST_RESP;
                        end else if (req_store) begin
                            resp_misalign <= 1'b0;
                            resp_valid    <= 1'b1;
                            state         <= ST_RESP;
                        end else begin
                            resp_misalign <= 1'b0;
                            ld_off        <= off;
                            ld_size       <= req_size;
                            ld_unsigned   <= req_unsigned;
                            state         <= ST_LOAD_WAIT;
                        end
                    end
                end
                ST_LOAD_WAIT: begin
                    // mem_rdata now holds the word addressed at accept.
                    resp_data  <= ld_data;
                    resp_valid <= 1'b1;
                    state      <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    resp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// -----------------------------------------------------------------------------
// tb_dmem_lsu
// Bench for dmem_lsu: directed vector table, randomized traffic against a
// byte-array reference model, and reset-during-load sequence.
// -----------------------------------------------------------------------------
module tb_dmem_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_tag;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic [4:0]  resp_tag;
    logic        resp_misalign;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wdata_sel;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

`ifdef DMEM_LSU_BOUND_CHK_EN
    localparam bit BOUND = 1'b1;
`else
    localparam bit BOUND = 1'b0;
`endif

    dmem_lsu dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_store     (req_store),
        .req_size      (req_size),
        .req_unsigned  (req_unsigned),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_tag       (req_tag),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_data     (resp_data),
        .resp_tag      (resp_tag),
        .resp_misalign (resp_misalign),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata_sel (mem_wdata_sel),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- data memory (1024 x 32, registered read) ----------------
    logic [31:0] mem_words [0:1023];
    always @(posedge clk) begin
        logic [31:0] w;
        w = mem_words[mem_addr[11:2]];
        if (mem_we) begin
            for (int b = 0; b < 4; b++)
                if (mem_wdata_sel[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
            mem_words[mem_addr[11:2]] <= w;
        end
        mem_rdata <= mem_words[mem_addr[11:2]];
    end

    // ---------------- reference model (byte array, low 64 bytes) ----------------
    logic [7:0] ref_mem [0:63];

    function automatic bit m_fault(input logic [1:0] sz, input logic [31:0] a);
        bit f;
        f = (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
        if (BOUND && a >= 32'h1000) f = 1'b1;
        return f;
    endfunction

    function automatic logic [3:0] m_sel(input logic [1:0] sz, input logic [31:0] a);
        int n;
        n = 1 << sz;
        return 4'(((1 << n) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] w;
        int n;
        n = 1 << sz;
        w = 0;
        for (int j = 0; j < 4; j++) w[8*j +: 8] = 8'(wd >> (8 * (j % n)));
        return w;
    endfunction

    task automatic m_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        for (int i = 0; i < (1 << sz); i++) ref_mem[(a + i) % 64] = 8'(wd >> (8 * i));
    endtask

    function automatic logic [31:0] m_load(input logic [1:0] sz, input bit uns,
                                           input logic [31:0] a);
        logic [31:0] v;
        int n;
        n = 1 << sz;
        v = 0;
        for (int i = 0; i < n; i++) v = v | (32'(ref_mem[(a + i) % 64]) << (8 * i));
        if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
        return v;
    endfunction

    // ---------------- scoreboard helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Called at a negedge with the DUT idle. Presents the request, records the
    // memory-side outputs of the accept cycle, scrambles the request bus after
    // accept, waits for the response (bounded), holds it for 'hold' cycles and
    // then consumes it.
    task automatic do_req(input string nm, input bit st, input logic [1:0] sz,
                          input bit uns, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [4:0] tag, input int hold,
                          input logic [31:0] e_data, input bit e_mis,
                          output logic o_we, output logic [3:0] o_sel,
                          output logic [31:0] o_maddr, output logic [31:0] o_mwd,
                          output int o_lat);
        req_store    = st;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        req_tag      = tag;
        req_valid    = 1'b1;
        #1;
        chk({nm, "_req_ready"}, 32'(req_ready), 32'd1);
        o_we    = mem_we;
        o_sel   = mem_wdata_sel;
        o_maddr = mem_addr;
        o_mwd   = mem_wdata;
        @(negedge clk);
        req_valid    = 1'b0;
        req_addr     = $urandom;
        req_wdata    = $urandom;
        req_size     = 2'($urandom);
        req_unsigned = 1'($urandom);
        req_tag      = 5'($urandom);
        o_lat = 1;
        while (!resp_valid && o_lat < 8) begin
            @(negedge clk);
            o_lat++;
        end
        for (int h = 0; h < hold; h++) begin
            chk({nm, "_hold_valid"}, 32'(resp_valid), 32'd1);
            chk({nm, "_hold_ready"}, 32'(req_ready), 32'd0);
            chk({nm, "_hold_data"}, resp_data, e_data);
            chk({nm, "_hold_mis"}, 32'(resp_misalign), 32'(e_mis));
            chk({nm, "_hold_tag"}, 32'(resp_tag), 32'(tag));
            @(negedge clk);
        end
        chk({nm, "_data"}, resp_data, e_data);
        chk({nm, "_mis"}, 32'(resp_misalign), 32'(e_mis));
        chk({nm, "_tag"}, 32'(resp_tag), 32'(tag));
        resp_ready = 1'b1;
        #1;
        chk({nm, "_noacc_resp"}, 32'(req_ready), 32'd0);
        @(negedge clk);
        resp_ready = 1'b0;
        chk({nm, "_rel_valid"}, 32'(resp_valid), 32'd0);
        chk({nm, "_rel_ready"}, 32'(req_ready), 32'd1);
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        bit          st;
        logic [1:0]  sz;
        bit          uns;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [4:0]  tag;
        int          hold;
        bit          e_we;
        logic [3:0]  e_sel;
        logic [31:0] e_maddr;
        logic [31:0] e_mwd;
        logic [31:0] e_data;
        bit          e_mis;
        int          e_lat;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit st, logic [1:0] sz, bit uns, logic [31:0] addr,
                                logic [31:0] wd, logic [4:0] tag, int hold, bit e_we,
                                logic [3:0] e_sel, logic [31:0] e_maddr,
                                logic [31:0] e_mwd, logic [31:0] e_data, bit e_mis,
                                int e_lat);
        vec_t v;
        v.st = st; v.sz = sz; v.uns = uns; v.addr = addr; v.wd = wd; v.tag = tag;
        v.hold = hold; v.e_we = e_we; v.e_sel = e_sel; v.e_maddr = e_maddr;
        v.e_mwd = e_mwd; v.e_data = e_data; v.e_mis = e_mis; v.e_lat = e_lat;
        return v;
    endfunction

    initial begin
        logic        o_we;
        logic [3:0]  o_sel;
        logic [31:0] o_maddr;
        logic [31:0] o_mwd;
        int          o_lat;
        string       nm;

        // ---------------- reset ----------------
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_store    = 1'b0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_addr     = 32'd0;
        req_wdata    = 32'd0;
        req_tag      = 5'd0;
        resp_ready   = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        chk("rst_resp_tag", 32'(resp_tag), 32'd0);
        chk("rst_resp_mis", 32'(resp_misalign), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        //              st sz uns addr        wdata        tag hold we sel     maddr         mwdata        data         mis lat
        vecs.push_back(mk(1, 2, 0, 32'h10, 32'hDEADBEEF, 1, 5, 1, 4'b1111, 32'h10, 32'hDEADBEEF, 32'h0,        0, 1));
        vecs.push_back(mk(1, 0, 0, 32'h13, 32'h000000A5, 2, 0, 1, 4'b1000, 32'h10, 32'hA5A5A5A5, 32'h0,        0, 1));
        vecs.push_back(mk(0, 0, 1, 32'h13, 32'h0,        3, 0, 0, 4'b0000, 32'h10, 32'h0,        32'h000000A5, 0, 2));
        vecs.push_back(mk(0, 0, 0, 32'h13, 32'h0,        4, 1, 0, 4'b0000, 32'h10, 32'h0,        32'hFFFFFFA5, 0, 2));
        vecs.push_back(mk(1, 2, 0, 32'h20, 32'h80011234, 5, 0, 1, 4'b1111, 32'h20, 32'h80011234, 32'h0,        0, 1));
        vecs.push_back(mk(0, 1, 0, 32'h22, 32'h0,        6, 0, 0, 4'b0000, 32'h20, 32'h0,        32'hFFFF8001, 0, 2));
        vecs.push_back(mk(0, 1, 1, 32'h22, 32'h0,        7, 3, 0, 4'b0000, 32'h20, 32'h0,        32'h00008001, 0, 2));
        vecs.push_back(mk(0, 1, 0, 32'h20, 32'h0,        8, 0, 0, 4'b0000, 32'h20, 32'h0,        32'h00001234, 0, 2));
        vecs.push_back(mk(0, 0, 0, 32'h21, 32'h0,       12, 0, 0, 4'b0000, 32'h20, 32'h0,        32'h00000012, 0, 2));
        vecs.push_back(mk(0, 0, 0, 32'h10, 32'h0,       13, 0, 0, 4'b0000, 32'h10, 32'h0,        32'hFFFFFFEF, 0, 2));
        vecs.push_back(mk(0, 2, 0, 32'h06, 32'h0,        9, 2, 0, 4'b0000, 32'h04, 32'h0,        32'h0,        1, 1));
        vecs.push_back(mk(1, 1, 0, 32'h01, 32'h1234,    10, 0, 0, 4'b0000, 32'h00, 32'h0,        32'h0,        1, 1));
        vecs.push_back(mk(0, 3, 0, 32'h00, 32'h0,       11, 0, 0, 4'b0000, 32'h00, 32'h0,        32'h0,        1, 1));
        vecs.push_back(mk(1, 1, 0, 32'h12, 32'h0000CAFE,14, 0, 1, 4'b1100, 32'h10, 32'hCAFECAFE, 32'h0,        0, 1));
        vecs.push_back(mk(0, 2, 0, 32'h10, 32'h0,       15, 0, 0, 4'b0000, 32'h10, 32'h0,        32'hCAFEBEEF, 0, 2));
`ifdef DMEM_LSU_BOUND_CHK_EN
        vecs.push_back(mk(1, 2, 0, 32'h1000, 32'h11223344, 16, 0, 0, 4'b0000, 32'h1000, 32'h0, 32'h0, 1, 1));
`else
        vecs.push_back(mk(1, 2, 0, 32'h1000, 32'h11223344, 16, 0, 1, 4'b1111, 32'h1000, 32'h11223344, 32'h0, 0, 1));
        vecs.push_back(mk(0, 2, 0, 32'h0, 32'h0, 17, 0, 0, 4'b0000, 32'h0, 32'h0, 32'h11223344, 0, 2));
`endif

        foreach (vecs[i]) begin
            nm = $sformatf("v%0d", i);
            do_req(nm, vecs[i].st, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].wd,
                   vecs[i].tag, vecs[i].hold, vecs[i].e_data, vecs[i].e_mis,
                   o_we, o_sel, o_maddr, o_mwd, o_lat);
            chk({nm, "_we"}, 32'(o_we), 32'(vecs[i].e_we));
            chk({nm, "_lat"}, 32'(o_lat), 32'(vecs[i].e_lat));
            if (!vecs[i].e_mis) begin
                chk({nm, "_sel"}, 32'(o_sel), 32'(vecs[i].e_sel));
                chk({nm, "_maddr"}, o_maddr, vecs[i].e_maddr);
                if (vecs[i].st) chk({nm, "_mwd"}, o_mwd, vecs[i].e_mwd);
            end
        end

        // ---------------- randomized traffic ----------------
        // Seed the low 64 bytes so every later load reads known data.
        for (int w = 0; w < 16; w++) begin
            logic [31:0] d;
            d = $urandom;
            do_req($sformatf("seed%0d", w), 1'b1, 2'd2, 1'b0, 32'(4 * w), d, 5'(w), 0,
                   32'd0, 1'b0, o_we, o_sel, o_maddr, o_mwd, o_lat);
            chk("seed_we", 32'(o_we), 32'd1);
            m_store(2'd2, 32'(4 * w), d);
        end

        for (int n = 0; n < 120; n++) begin
            bit          st;
            bit          uns;
            bit          f;
            logic [1:0]  sz;
            logic [31:0] a;
            logic [31:0] wd;
            logic [31:0] e_data;
            logic [4:0]  tag;
            st  = 1'($urandom_range(0, 1));
            uns = 1'($urandom_range(0, 1));
            sz  = (n % 10 == 9) ? 2'd3 : 2'($urandom_range(0, 2));
            a   = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 5) == 0) a = a | (32'($urandom_range(1, 15)) << 12);
            wd  = $urandom;
            tag = 5'($urandom);
            f   = m_fault(sz, a);
            e_data = (st || f) ? 32'd0 : m_load(sz, uns, a);
            nm = $sformatf("r%0d", n);
            do_req(nm, st, sz, uns, a, wd, tag, $urandom_range(0, 3), e_data, f,
                   o_we, o_sel, o_maddr, o_mwd, o_lat);
            chk({nm, "_we"}, 32'(o_we), 32'(st && !f));
            chk({nm, "_lat"}, 32'(o_lat), (st || f) ? 32'd1 : 32'd2);
            if (!f) begin
                chk({nm, "_maddr"}, o_maddr, a - (a % 4));
                chk({nm, "_sel"}, 32'(o_sel), st ? 32'(m_sel(sz, a)) : 32'd0);
                if (st) begin
                    chk({nm, "_mwd"}, o_mwd, m_wdata(sz, wd));
                    m_store(sz, a, wd);
                end
            end
        end

        // ---------------- reset during LOAD_WAIT ----------------
        req_store    = 1'b0;
        req_size     = 2'd2;
        req_unsigned = 1'b0;
        req_addr     = 32'h10;
        req_tag      = 5'd21;
        req_valid    = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rst_lw_state", 32'(req_ready), 32'd0);
        // A store is presented while reset is asserted: it must not write.
        rst_n     = 1'b0;
        req_store = 1'b1;
        req_addr  = 32'h30;
        req_valid = 1'b1;
        #1;
        chk("rst_lw_valid", 32'(resp_valid), 32'd0);
        chk("rst_lw_ready", 32'(req_ready), 32'd1);
        chk("rst_lw_we", 32'(mem_we), 32'd0);
        @(negedge clk);
        chk("rst_hold_we", 32'(mem_we), 32'd0);
        req_valid = 1'b0;
        rst_n     = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_valid", 32'(resp_valid), 32'd0);
        chk("post_rst_data", resp_data, 32'd0);
        chk("post_rst_ready", 32'(req_ready), 32'd1);
        // Word at 0x30 must be untouched by the store presented during reset.
        do_req("post_rst_lw", 1'b0, 2'd2, 1'b0, 32'h30, 32'd0, 5'd22, 0,
               m_load(2'd2, 1'b0, 32'h30), 1'b0, o_we, o_sel, o_maddr, o_mwd, o_lat);
        chk("post_rst_lw_lat", 32'(o_lat), 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time bound so a stuck DUT can never hang the run.
    initial begin
        #500000;
        $display("FAIL timeout actual=running required=finished");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

endmodule
